// File: rtl/fan_pkg.sv
// Shared types, default rates and the level-to-duty mapping for the fan driver.
package fan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KICK = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } fan_state_e;

    localparam int unsigned FAN_CLK_HZ_DEF  = 100_000_000;
    localparam int unsigned FAN_TICK_HZ_DEF = 100_000;

    // Floor of lvl*period/(levels-1); top level maps to full duty.
    function automatic int unsigned level_to_duty(input int unsigned lvl,
                                                  input int unsigned period,
                                                  input int unsigned levels);
        return (lvl * period) / (levels - 1);
    endfunction

endpackage

// File: rtl/fan_pwm_ctrl_n_tick_gen_div.sv
// Prescaler: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module tick_gen_div #(
    parameter int unsigned DIV = 10
) (
    input  logic sysclk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Free-running divider, wraps after DIV-1.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/fan_pwm_ctrl_n.sv
// N-level fan PWM driver with kick-start, soft ramp and boundary-aligned duty updates.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | fan stopped, working duty 0, waiting for a non-zero target
//  KICK  | full duty for KICK_PERIODS PWM periods after leaving IDLE
//  RAMP  | working duty steps by 1 toward target every RAMP_TICKS ticks
//  HOLD  | working duty equals target
module fan_pwm_ctrl_n
    import fan_pkg::*;
#(
    parameter int unsigned CLK_HZ       = FAN_CLK_HZ_DEF,
    parameter int unsigned TICK_HZ      = FAN_TICK_HZ_DEF,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned LEVELS       = 4,
    parameter int unsigned RAMP_TICKS   = 50,
    parameter int unsigned KICK_PERIODS = 20,
    parameter int unsigned LVL_W        = $clog2(LEVELS),
    parameter int unsigned DUTY_W       = $clog2(PERIOD + 1)
) (
    input  logic              sysclk,
    input  logic              i_rst,
    input  logic [LVL_W-1:0]  i_level,
    input  logic              i_ramp_en,
    output logic              o_PWMout,
    output logic [DUTY_W-1:0] o_duty,
    output logic [1:0]        o_state,
    output logic              o_busy
);

    localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
    localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned KICK_W = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_KICK = ST_KICK;
    localparam logic [1:0] S_RAMP = ST_RAMP;
    localparam logic [1:0] S_HOLD = ST_HOLD;

    logic              w_tick;
    logic              w_bound;
    logic [PCNT_W-1:0] r_pcnt;
    logic [DUTY_W-1:0] w_pcnt_ext;
    logic [LVL_W-1:0]  r_lvl;
    logic [DUTY_W-1:0] w_tgt;
    logic [DUTY_W-1:0] r_cur;
    logic [DUTY_W-1:0] r_duty;
    logic              r_pwm;
    logic [1:0]        r_state;
    logic [KICK_W-1:0] r_kick;
    logic [RAMP_W-1:0] r_rcnt;

    tick_gen_div #(.DIV(DIV)) u_tick (
        .sysclk (sysclk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // PWM position within the period, advanced once per tick.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= (r_pcnt == PCNT_W'(PERIOD - 1)) ? '0 : r_pcnt + 1'b1;
        end
    end

    assign w_bound    = w_tick && (r_pcnt == PCNT_W'(PERIOD - 1));
    assign w_pcnt_ext = DUTY_W'(r_pcnt);

    // Requested level, clamped to the top level before it reaches the target math.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_lvl <= '0;
        end else if (32'(i_level) >= LEVELS) begin
            r_lvl <= LVL_W'(LEVELS - 1);
        end else begin
            r_lvl <= i_level;
        end
    end

    assign w_tgt = DUTY_W'(level_to_duty(32'(r_lvl), PERIOD, LEVELS));

    // Applied duty only changes on the wrap so a period is never cut short; output is registered.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (w_bound) begin
                r_duty <= r_cur;
            end
            r_pwm <= (w_pcnt_ext < r_duty);
        end
    end

    // Sequencing of the working duty: kick, ramp, hold, idle.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_kick  <= '0;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cur <= '0;
                    if (w_tgt != '0) begin
                        r_state <= S_KICK;
                        r_cur   <= DUTY_W'(PERIOD);
                        r_kick  <= '0;
                    end
                end
                S_KICK: begin
                    if (w_tgt == '0) begin
                        r_state <= S_IDLE;
                        r_cur   <= '0;
                    end else if (w_bound) begin
                        if (r_kick == KICK_W'(KICK_PERIODS - 1)) begin
                            r_rcnt <= '0;
                            if (i_ramp_en) begin
                                r_state <= S_RAMP;
                            end else begin
                                r_cur   <= w_tgt;
                                r_state <= S_HOLD;
                            end
                        end else begin
                            r_kick <= r_kick + 1'b1;
                        end
                    end
                end
                S_RAMP: begin
                    if (!i_ramp_en) begin
                        r_cur   <= w_tgt;
                        r_state <= S_HOLD;
                    end else if (r_cur == w_tgt) begin
                        r_state <= (w_tgt == '0) ? S_IDLE : S_HOLD;
                    end else if (w_tick) begin
                        if (r_rcnt == RAMP_W'(RAMP_TICKS - 1)) begin
                            r_rcnt <= '0;
                            r_cur  <= (r_cur < w_tgt) ? r_cur + 1'b1 : r_cur - 1'b1;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tgt != r_cur) begin
                        if (i_ramp_en) begin
                            r_state <= S_RAMP;
                            r_rcnt  <= '0;
                        end else begin
                            r_cur <= w_tgt;
                        end
                    end else if (w_tgt == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cur   <= '0;
                end
            endcase
        end
    end

    assign o_PWMout = r_pwm;
    assign o_duty   = r_duty;
    assign o_state  = r_state;
    assign o_busy   = (r_state == S_KICK) || (r_state == S_RAMP);

endmodule

// File: doc/fan_pwm_ctrl_n.md
Name: fan_pwm_ctrl_n

Overview:
Parametrised fan driver that generalises the fixed four-speed fan controller to N speed levels with a configurable PWM period.
- Adds kick-start (full duty for a set time when spinning up from stop) and a soft duty ramp between levels.
- Duty changes are applied glitch-free, only at PWM period boundaries.
- Sits between the user/speed-select logic and the fan driver pin. Exports current duty and state for the FND and status logic.

Parameters:
- CLK_HZ, 100_000_000: sysclk frequency.
- TICK_HZ, 100_000: PWM tick rate. CLK_HZ/TICK_HZ must be an integer ≥2.
- PERIOD, 100: ticks per PWM period. Duty resolution is 0..PERIOD.
- LEVELS, 4: number of speed levels, ≥2. Level 0 = off; level LEVELS-1 = 100 %.
- RAMP_TICKS, 50: ticks between successive 1-step duty changes during ramp.
- KICK_PERIODS, 20: PWM periods of full duty on spin-up from stop.
- LVL_W, $clog2(LEVELS): level port width (derived).
- DUTY_W, $clog2(PERIOD+1): duty width (derived).

Ports:
- sysclk, input, 1: system clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_level, input, LVL_W: requested speed level. Values ≥LEVELS are clamped to LEVELS-1.
- i_ramp_en, input, 1: 1 = soft ramp; 0 = jump straight to target.
- o_PWMout, output, 1: fan PWM.
- o_duty, output, DUTY_W: duty currently applied (registered).
- o_state, output, 2: FSM state, encoded IDLE=0, KICK=1, RAMP=2, HOLD=3.
- o_busy, output, 1: high in KICK or RAMP.

Behaviour:
- Reset
  - Synchronous, active-high on sysclk. All counters, o_duty, o_PWMout and o_busy go to 0; state goes to IDLE.
  - Asserting i_rst mid-operation forces outputs to 0 on the next edge. No kick or ramp state is retained.
- Prescaler
  - Counter runs 0..CLK_HZ/TICK_HZ-1 and emits a 1-cycle tick on wrap.
- PWM counter (pcnt)
  - Runs 0..PERIOD-1 and advances on tick.
  - The period boundary is the tick on which pcnt wraps to 0.
- Target duty
  - tgt = lvl*PERIOD/(LEVELS-1), integer floor, using the clamped level.
  - i_level is registered once; tgt is recomputed every cycle.
- Working and applied duty
  - cur is the working duty. o_duty loads cur only at a period boundary.
  - o_PWMout = (pcnt < o_duty), registered: 1 cycle latency after pcnt.
  - o_duty = 0 gives constant low; o_duty = PERIOD gives constant high.
- FSM
  - IDLE: cur=0. If tgt>0, go to KICK, set cur=PERIOD, clear the kick counter.
  - KICK: cur=PERIOD; the kick counter counts period boundaries.
    - If tgt becomes 0, go to IDLE immediately with cur=0 (abort).
    - After KICK_PERIODS boundaries, go to RAMP. If i_ramp_en=0, set cur=tgt and go to HOLD.
    - Level changes during KICK do not restart the kick; the latest tgt is used on exit.
  - RAMP: every RAMP_TICKS ticks, cur moves 1 toward tgt.
    - Go to HOLD when cur==tgt.
    - If tgt changes mid-ramp, continue from the current cur toward the new tgt; direction reversal is allowed.
    - If i_ramp_en drops, set cur=tgt and go to HOLD next cycle.
    - If cur reaches 0 with tgt==0, go to IDLE.
  - HOLD: if tgt≠cur, go to RAMP (or set cur=tgt when i_ramp_en=0). If tgt==0 and cur==0, go to IDLE.
  - The ramp tick counter is cleared on every entry to RAMP.
  - Spin-down never kicks; kick occurs only on leaving IDLE.
- Simultaneous events: period boundary and a ramp step in the same cycle. The step updates cur; o_duty captures the pre-step cur, and the new value applies at the next boundary.
- o_busy = (state==KICK || state==RAMP).

Decomposition:
- Shared package fan_pkg holds:
  - State enum (IDLE/KICK/RAMP/HOLD, 2-bit).
  - Default CLK_HZ and TICK_HZ constants.
  - Function level_to_duty(lvl, PERIOD, LEVELS).
- One sub-module: tick_gen_div. Parametrised divisor prescaler with sysclk, i_rst, o_tick.
- PWM counter, FSM and ramp stay in the top module.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (div 10), PERIOD=10, LEVELS=4 (duties 0,3,6,10), RAMP_TICKS=2, KICK_PERIODS=2.
- Reset: i_rst=1 for 3 cycles with i_level=3 → o_PWMout=0, o_duty=0, o_state=0, o_busy=0 throughout and on the first cycle after release.
- Spin-up, ramp on: i_level 0→2 → state KICK, o_PWMout high for 200 cycles. Then RAMP with cur 10→9→8→7→6, one step per 20 cycles. Then HOLD with o_duty=6, i.e. 60 high / 40 low per 100-cycle period.
- Ramp off: i_ramp_en=0, i_level 0→1 → 2 kick periods at duty 10. At the next boundary o_duty=3 and state goes directly to HOLD.
- Abort kick: i_level 0→3, then 0 after 50 cycles → state IDLE next cycle. o_PWMout low from the next period boundary; no RAMP entered.
- Reversal: in HOLD at 10, set i_level=1, then i_level=3 once cur=7 → cur climbs back 8,9,10, then HOLD. o_duty never changes mid-period.
- Clamp and reset mid-ramp: i_level=5 on LVL_W=3 with LEVELS=5 → target PERIOD. Assert i_rst during RAMP → all outputs 0 next edge, state IDLE.
